// File: rtl/time_set_sequencer.sv
// Button-driven time-set sequencer: debounces mode/inc/dec, edits shadow copies of the time, commits via load_en.
// Optional auto-repeat of held inc/dec is enabled by defining TIME_SET_AUTO_REPEAT_EN.
module time_set_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_TICKS   = 10,
    parameter int unsigned REPEAT_DELAY    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       cur_pm,
    output logic       pause,
    output logic       load_en,
    output logic [3:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic       load_pm,
    output logic [1:0] edit_field,
    output logic       blink
);

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TO_W    = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_TICKS < 1 || REPEAT_DELAY < 1) begin : g_param_check
        $error("time_set_sequencer: DEBOUNCE_CYCLES>=2, TIMEOUT_TICKS>=1, REPEAT_DELAY>=1 required");
    end

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_SET_HOUR = 3'd1,
        S_SET_MIN  = 3'd2,
        S_SET_SEC  = 3'd3,
        S_COMMIT   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Button conditioning: index 0 mode, 1 inc, 2 dec
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] deb_prev;
    logic [DB_W-1:0]    db_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = deb & ~deb_prev;

    logic in_set;
    logic rep_inc;
    logic rep_dec;
    logic ev_inc;
    logic ev_dec;
    logic mode_hit;
    logic inc_hit;
    logic dec_hit;
    logic accepted;
    logic timeout_hit;
    logic [TO_W-1:0] to_cnt;

    assign in_set = (state == S_SET_HOUR) || (state == S_SET_MIN) || (state == S_SET_SEC);

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic              held;
    logic              rep_fire;

    // Exactly one of inc/dec held inside an edit session drives the repeat timer
    assign held     = in_set && (deb[1] ^ deb[2]);
    assign rep_fire = held && tick_1hz && (hold_cnt == HOLD_W'(REPEAT_DELAY));
    assign rep_inc  = rep_fire && deb[1];
    assign rep_dec  = rep_fire && deb[2];

    always_ff @(posedge clk) begin
        if (!rst_n || !held) begin
            hold_cnt <= '0;
        end else if (tick_1hz && (hold_cnt != HOLD_W'(REPEAT_DELAY))) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;
`endif

    // Mode beats inc/dec; simultaneous inc and dec cancel each other
    assign ev_inc      = press[1] | rep_inc;
    assign ev_dec      = press[2] | rep_dec;
    assign mode_hit    = press[0];
    assign inc_hit     = !mode_hit && ev_inc && !ev_dec;
    assign dec_hit     = !mode_hit && ev_dec && !ev_inc;
    assign accepted    = mode_hit || inc_hit || dec_hit;
    assign timeout_hit = in_set && !accepted && tick_1hz &&
                         (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !in_set || accepted || timeout_hit) begin
            to_cnt <= '0;
        end else if (tick_1hz) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_RUN:      if (mode_hit) next_state = S_SET_HOUR;
            S_SET_HOUR: if (mode_hit) next_state = S_SET_MIN;
                        else if (timeout_hit) next_state = S_RUN;
            S_SET_MIN:  if (mode_hit) next_state = S_SET_SEC;
                        else if (timeout_hit) next_state = S_RUN;
            S_SET_SEC:  if (mode_hit) next_state = S_COMMIT;
                        else if (timeout_hit) next_state = S_RUN;
            S_COMMIT:   next_state = S_RUN;
            default:    next_state = S_RUN;
        endcase
    end

    logic       pause_d;
    logic       load_en_d;
    logic [1:0] edit_field_d;
    logic       blink_d;

    // Output logic: next values of the registered control outputs
    always_comb begin
        pause_d      = 1'b0;
        load_en_d    = 1'b0;
        edit_field_d = 2'd0;
        blink_d      = blink;
        unique case (next_state)
            S_SET_HOUR: begin pause_d = 1'b1; edit_field_d = 2'd1; end
            S_SET_MIN:  begin pause_d = 1'b1; edit_field_d = 2'd2; end
            S_SET_SEC:  begin pause_d = 1'b1; edit_field_d = 2'd3; end
            S_COMMIT:   begin pause_d = 1'b1; load_en_d = 1'b1; end
            default:    ;
        endcase
        if (next_state == S_RUN || next_state == S_COMMIT || state == S_RUN) begin
            blink_d = 1'b0;
        end else if (tick_1hz) begin
            blink_d = ~blink;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pause      <= 1'b0;
            load_en    <= 1'b0;
            edit_field <= 2'd0;
            blink      <= 1'b0;
        end else begin
            pause      <= pause_d;
            load_en    <= load_en_d;
            edit_field <= edit_field_d;
            blink      <= blink_d;
        end
    end

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec60(input logic [5:0] v);
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Shadow registers: snapshot on session entry, then edit only the active field
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_hour <= 4'd12;
            load_min  <= 6'd0;
            load_sec  <= 6'd0;
            load_pm   <= 1'b0;
        end else if (state == S_RUN) begin
            if (mode_hit) begin
                load_hour <= cur_hour;
                load_min  <= cur_min;
                load_sec  <= cur_sec;
                load_pm   <= cur_pm;
            end
        end else begin
            unique case (state)
                S_SET_HOUR: begin
                    if (inc_hit) begin
                        load_hour <= (load_hour >= 4'd12) ? 4'd1 : load_hour + 4'd1;
                        if (load_hour == 4'd11) load_pm <= ~load_pm;
                    end else if (dec_hit) begin
                        load_hour <= (load_hour <= 4'd1) ? 4'd12 : load_hour - 4'd1;
                        if (load_hour == 4'd12) load_pm <= ~load_pm;
                    end
                end
                S_SET_MIN: begin
                    if (inc_hit)      load_min <= inc60(load_min);
                    else if (dec_hit) load_min <= dec60(load_min);
                end
                S_SET_SEC: begin
                    if (inc_hit)      load_sec <= inc60(load_sec);
                    else if (dec_hit) load_sec <= dec60(load_sec);
                end
                default: ;
            endcase
        end
    end

endmodule
